// File: rtl/wb_ctrl_pkg.sv
// Shared register-file widths and the write-request record used by the write-back path.
package riscv_defines;

    localparam int ADDR_WIDTH = 5;
    localparam int WORD_WIDTH = 32;
    localparam int N_OF_REGS  = 32;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] data;
    } wb_req_t;

    function automatic logic is_x0(input logic [ADDR_WIDTH-1:0] addr);
        return (addr == {ADDR_WIDTH{1'b0}});
    endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// Bundle of ALU, LSU, decode-read and bank-write signals around the write-back controller.
interface wb_ctrl_if;
    import riscv_defines::*;

    logic                  alu_wb_valid_i;
    logic [ADDR_WIDTH-1:0] alu_wb_addr_i;
    logic [WORD_WIDTH-1:0] alu_wb_data_i;
    logic                  alu_stall_o;
    logic                  lsu_issue_i;
    logic [ADDR_WIDTH-1:0] lsu_issue_addr_i;
    logic                  lsu_rsp_valid_i;
    logic                  lsu_rsp_ready_o;
    logic [ADDR_WIDTH-1:0] lsu_rsp_addr_i;
    logic [WORD_WIDTH-1:0] lsu_rsp_data_i;
    logic [ADDR_WIDTH-1:0] read_addr1_i;
    logic [ADDR_WIDTH-1:0] read_addr2_i;
    logic [WORD_WIDTH-1:0] read_data1_i;
    logic [WORD_WIDTH-1:0] read_data2_i;
    logic [WORD_WIDTH-1:0] read_data1_o;
    logic [WORD_WIDTH-1:0] read_data2_o;
    logic                  hazard_o;
    logic                  write_en_o;
    logic [ADDR_WIDTH-1:0] write_addr_o;
    logic [WORD_WIDTH-1:0] write_data_o;

    modport slave (
        input  alu_wb_valid_i, alu_wb_addr_i, alu_wb_data_i,
        input  lsu_issue_i, lsu_issue_addr_i,
        input  lsu_rsp_valid_i, lsu_rsp_addr_i, lsu_rsp_data_i,
        input  read_addr1_i, read_addr2_i, read_data1_i, read_data2_i,
        output alu_stall_o, lsu_rsp_ready_o,
        output read_data1_o, read_data2_o, hazard_o,
        output write_en_o, write_addr_o, write_data_o
    );

    modport master (
        output alu_wb_valid_i, alu_wb_addr_i, alu_wb_data_i,
        output lsu_issue_i, lsu_issue_addr_i,
        output lsu_rsp_valid_i, lsu_rsp_addr_i, lsu_rsp_data_i,
        output read_addr1_i, read_addr2_i, read_data1_i, read_data2_i,
        input  alu_stall_o, lsu_rsp_ready_o,
        input  read_data1_o, read_data2_o, hazard_o,
        input  write_en_o, write_addr_o, write_data_o
    );

endinterface

// File: rtl/wb_ctrl_chk.sv
// Protocol checks on the scoreboard and write port of the write-back controller.
module wb_ctrl_chk #(
    parameter int ADDR_WIDTH = 5,
    parameter int N_OF_REGS  = 32
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  issue,
    input logic [ADDR_WIDTH-1:0] issue_addr,
    input logic                  alu_valid,
    input logic [ADDR_WIDTH-1:0] alu_addr,
    input logic                  clr_en,
    input logic [ADDR_WIDTH-1:0] clr_addr,
    input logic [N_OF_REGS-1:0]  pending,
    input logic                  write_en,
    input logic [ADDR_WIDTH-1:0] write_addr
);

    // A register already waiting on a load must not get a second producer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(issue && pending[issue_addr] && !(clr_en && (clr_addr == issue_addr))))
                else $error("wb_ctrl: load issued to pending register %0d", issue_addr);
            assert (!(alu_valid && pending[alu_addr]))
                else $error("wb_ctrl: ALU write to pending register %0d", alu_addr);
            assert (!(write_en && (write_addr == {ADDR_WIDTH{1'b0}})))
                else $error("wb_ctrl: bank write to x0");
        end
    end

endmodule

// File: rtl/wb_ctrl_fifo.sv
// Small synchronous FIFO of write requests buffering LSU load responses.
module wb_fifo
    import riscv_defines::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push_i,
    input  logic    pop_i,
    input  wb_req_t wdata_i,
    output wb_req_t rdata_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(32'd1);
    localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W + 1)'(32'd1);
    localparam logic [PTR_W:0]    CNT_FULL = (PTR_W + 1)'(DEPTH);

    wb_req_t          mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_r == CNT_FULL);
    assign empty_o   = (count_r == {(PTR_W + 1){1'b0}});
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign rdata_o   = mem_r[rd_ptr_r];

    // Storage, pointers (wrapping by power-of-2 overflow) and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {$bits(wb_req_t){1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata_i;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/wb_ctrl.sv
// Write-back controller: arbitrates ALU results and buffered load data onto the single bank
// write port, tracks loads in flight, and forwards the write in progress to decode.
module wb_ctrl #(
    parameter int ADDR_WIDTH     = riscv_defines::ADDR_WIDTH,
    parameter int WORD_WIDTH     = riscv_defines::WORD_WIDTH,
    parameter int N_OF_REGS      = riscv_defines::N_OF_REGS,
    parameter int LSU_FIFO_DEPTH = 2
) (
    input logic      clk,
    input logic      rst,
    wb_ctrl_if.slave bus
);

    riscv_defines::wb_req_t rsp_s;
    riscv_defines::wb_req_t head_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   alu_win_s;
    logic                   clr_en_s;

    logic                   write_en_r;
    logic [ADDR_WIDTH-1:0]  write_addr_r;
    logic [WORD_WIDTH-1:0]  write_data_r;
    logic                   write_en_nxt_s;
    logic [ADDR_WIDTH-1:0]  write_addr_nxt_s;
    logic [WORD_WIDTH-1:0]  write_data_nxt_s;
    logic [N_OF_REGS-1:0]   pending_r;
    logic [N_OF_REGS-1:0]   pending_nxt_s;

    assign rsp_s               = {bus.lsu_rsp_addr_i, bus.lsu_rsp_data_i};
    assign push_s              = bus.lsu_rsp_valid_i && !fifo_full_s;
    assign bus.lsu_rsp_ready_o = !fifo_full_s;
    assign bus.alu_stall_o     = fifo_full_s && bus.alu_wb_valid_i;
    assign clr_en_s            = pop_s && !riscv_defines::is_x0(head_s.addr);

    wb_fifo #(.DEPTH(LSU_FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (rsp_s),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Single winner per cycle; a full buffer pre-empts the ALU so loads cannot starve.
    always_comb begin
        alu_win_s = 1'b0;
        pop_s     = 1'b0;
        if (fifo_full_s) begin
            pop_s = 1'b1;
        end else if (bus.alu_wb_valid_i && !riscv_defines::is_x0(bus.alu_wb_addr_i)) begin
            alu_win_s = 1'b1;
        end else if (!fifo_empty_s) begin
            pop_s = 1'b1;
        end else begin
            alu_win_s = 1'b0;
            pop_s     = 1'b0;
        end
    end

    // Next write-port contents; x0 entries still drain but never raise the enable.
    always_comb begin
        write_en_nxt_s   = 1'b0;
        write_addr_nxt_s = write_addr_r;
        write_data_nxt_s = write_data_r;
        if (alu_win_s) begin
            write_en_nxt_s   = 1'b1;
            write_addr_nxt_s = bus.alu_wb_addr_i;
            write_data_nxt_s = bus.alu_wb_data_i;
        end else if (pop_s) begin
            write_en_nxt_s   = clr_en_s;
            write_addr_nxt_s = head_s.addr;
            write_data_nxt_s = head_s.data;
        end else begin
            write_en_nxt_s = 1'b0;
        end
    end

    // Scoreboard update: clear on pop first so a same-cycle issue of that register wins.
    always_comb begin
        pending_nxt_s = pending_r;
        if (clr_en_s) begin
            pending_nxt_s[head_s.addr] = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
        if (bus.lsu_issue_i && !riscv_defines::is_x0(bus.lsu_issue_addr_i)) begin
            pending_nxt_s[bus.lsu_issue_addr_i] = 1'b1;
        end else begin
            pending_nxt_s[0] = 1'b0;
        end
        pending_nxt_s[0] = 1'b0;
    end

    // Registered write port and scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_en_r   <= 1'b0;
            write_addr_r <= {ADDR_WIDTH{1'b0}};
            write_data_r <= {WORD_WIDTH{1'b0}};
            pending_r    <= {N_OF_REGS{1'b0}};
        end else begin
            write_en_r   <= write_en_nxt_s;
            write_addr_r <= write_addr_nxt_s;
            write_data_r <= write_data_nxt_s;
            pending_r    <= pending_nxt_s;
        end
    end

    // Decode-side view: hazard on pending sources, bypass of the write in flight.
    always_comb begin
        bus.hazard_o = pending_r[bus.read_addr1_i] || pending_r[bus.read_addr2_i];
        if (write_en_r && (write_addr_r == bus.read_addr1_i) && !riscv_defines::is_x0(bus.read_addr1_i)) begin
            bus.read_data1_o = write_data_r;
        end else begin
            bus.read_data1_o = bus.read_data1_i;
        end
        if (write_en_r && (write_addr_r == bus.read_addr2_i) && !riscv_defines::is_x0(bus.read_addr2_i)) begin
            bus.read_data2_o = write_data_r;
        end else begin
            bus.read_data2_o = bus.read_data2_i;
        end
    end

    assign bus.write_en_o   = write_en_r;
    assign bus.write_addr_o = write_addr_r;
    assign bus.write_data_o = write_data_r;

    wb_ctrl_chk #(.ADDR_WIDTH(ADDR_WIDTH), .N_OF_REGS(N_OF_REGS)) u_chk (
        .clk        (clk),
        .rst        (rst),
        .issue      (bus.lsu_issue_i),
        .issue_addr (bus.lsu_issue_addr_i),
        .alu_valid  (bus.alu_wb_valid_i),
        .alu_addr   (bus.alu_wb_addr_i),
        .clr_en     (clr_en_s),
        .clr_addr   (head_s.addr),
        .pending    (pending_r),
        .write_en   (write_en_r),
        .write_addr (write_addr_r)
    );

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl: forwarding, load hazards, arbitration under a full buffer,
// x0 handling, same-cycle scoreboard set/clear and asynchronous reset.
module tb_wb_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wb_ctrl_if bus ();

    wb_ctrl #(.LSU_FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".en"}, 32'(bus.write_en_o), 32'(en));
        if (en) begin
            chk({tag, ".addr"}, 32'(bus.write_addr_o), 32'(a));
            chk({tag, ".data"}, bus.write_data_o, d);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.alu_wb_valid_i   = 1'b0;
        bus.alu_wb_addr_i    = 5'd0;
        bus.alu_wb_data_i    = 32'd0;
        bus.lsu_issue_i      = 1'b0;
        bus.lsu_issue_addr_i = 5'd0;
        bus.lsu_rsp_valid_i  = 1'b0;
        bus.lsu_rsp_addr_i   = 5'd0;
        bus.lsu_rsp_data_i   = 32'd0;
        bus.read_addr1_i     = 5'd0;
        bus.read_addr2_i     = 5'd0;
        bus.read_data1_i     = 32'h1111_1111;
        bus.read_data2_i     = 32'h2222_2222;
    endtask

    initial begin
        idle();
        #1;
        chk("rst.en",    32'(bus.write_en_o), 32'd0);
        chk("rst.addr",  32'(bus.write_addr_o), 32'd0);
        chk("rst.data",  bus.write_data_o, 32'd0);
        chk("rst.ready", 32'(bus.lsu_rsp_ready_o), 32'd1);
        chk("rst.haz",   32'(bus.hazard_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // ALU write with same-cycle forwarding to read port 1
        bus.alu_wb_valid_i = 1'b1;
        bus.alu_wb_addr_i  = 5'd5;
        bus.alu_wb_data_i  = 32'hDEAD_BEEF;
        bus.read_addr1_i   = 5'd5;
        #1;
        chk("alu.stall", 32'(bus.alu_stall_o), 32'd0);
        chk("alu.pre_fwd", bus.read_data1_o, 32'h1111_1111);
        tick();
        bus.alu_wb_valid_i = 1'b0;
        chk_wr("alu.wr", 1'b1, 5'd5, 32'hDEAD_BEEF);
        chk("alu.fwd1", bus.read_data1_o, 32'hDEAD_BEEF);
        chk("alu.nofwd2", bus.read_data2_o, 32'h2222_2222);
        tick();
        chk_wr("alu.done", 1'b0, 5'd0, 32'd0);

        // Load hazard on r7 until its response pops
        idle();
        bus.lsu_issue_i      = 1'b1;
        bus.lsu_issue_addr_i = 5'd7;
        bus.read_addr2_i     = 5'd7;
        #1;
        chk("ld.haz_pre", 32'(bus.hazard_o), 32'd0);
        tick();
        bus.lsu_issue_i = 1'b0;
        chk("ld.haz_set", 32'(bus.hazard_o), 32'd1);
        tick();
        chk("ld.haz_hold", 32'(bus.hazard_o), 32'd1);
        bus.lsu_rsp_valid_i = 1'b1;
        bus.lsu_rsp_addr_i  = 5'd7;
        bus.lsu_rsp_data_i  = 32'h0000_1234;
        #1;
        chk("ld.ready", 32'(bus.lsu_rsp_ready_o), 32'd1);
        tick();
        bus.lsu_rsp_valid_i = 1'b0;
        chk_wr("ld.push", 1'b0, 5'd0, 32'd0);
        chk("ld.haz_push", 32'(bus.hazard_o), 32'd1);
        tick();
        chk_wr("ld.wr", 1'b1, 5'd7, 32'h0000_1234);
        chk("ld.haz_clr", 32'(bus.hazard_o), 32'd0);
        chk("ld.fwd2", bus.read_data2_o, 32'h0000_1234);

        // Continuous ALU traffic against three load responses
        idle();
        bus.alu_wb_valid_i  = 1'b1;
        bus.alu_wb_addr_i   = 5'd3;
        bus.alu_wb_data_i   = 32'hA0;
        bus.lsu_rsp_valid_i = 1'b1;
        bus.lsu_rsp_addr_i  = 5'd10;
        bus.lsu_rsp_data_i  = 32'hB0;
        #1;
        chk("st.ready0", 32'(bus.lsu_rsp_ready_o), 32'd1);
        chk("st.stall0", 32'(bus.alu_stall_o), 32'd0);
        tick();
        chk_wr("st.w1", 1'b1, 5'd3, 32'hA0);
        bus.alu_wb_data_i  = 32'hA1;
        bus.lsu_rsp_addr_i = 5'd11;
        bus.lsu_rsp_data_i = 32'hB1;
        tick();
        chk_wr("st.w2", 1'b1, 5'd3, 32'hA1);
        bus.alu_wb_data_i  = 32'hA2;
        bus.lsu_rsp_addr_i = 5'd12;
        bus.lsu_rsp_data_i = 32'hB2;
        #1;
        chk("st.ready_full", 32'(bus.lsu_rsp_ready_o), 32'd0);
        chk("st.stall_full", 32'(bus.alu_stall_o), 32'd1);
        tick();
        chk_wr("st.w3", 1'b1, 5'd10, 32'hB0);
        chk("st.ready3", 32'(bus.lsu_rsp_ready_o), 32'd1);
        chk("st.stall3", 32'(bus.alu_stall_o), 32'd0);
        tick();
        chk_wr("st.w4", 1'b1, 5'd3, 32'hA2);
        bus.alu_wb_data_i   = 32'hA3;
        bus.lsu_rsp_valid_i = 1'b0;
        #1;
        chk("st.stall4", 32'(bus.alu_stall_o), 32'd1);
        tick();
        chk_wr("st.w5", 1'b1, 5'd11, 32'hB1);
        tick();
        bus.alu_wb_valid_i = 1'b0;
        chk_wr("st.w6", 1'b1, 5'd3, 32'hA3);
        tick();
        chk_wr("st.w7", 1'b1, 5'd12, 32'hB2);
        tick();
        chk_wr("st.w8", 1'b0, 5'd0, 32'd0);

        // x0 requests from both sources never reach the bank
        idle();
        bus.alu_wb_valid_i  = 1'b1;
        bus.alu_wb_data_i   = 32'hFF;
        bus.lsu_rsp_valid_i = 1'b1;
        bus.lsu_rsp_data_i  = 32'hEE;
        #1;
        chk("x0.stall", 32'(bus.alu_stall_o), 32'd0);
        tick();
        idle();
        chk_wr("x0.alu", 1'b0, 5'd0, 32'd0);
        tick();
        chk_wr("x0.pop", 1'b0, 5'd0, 32'd0);
        bus.lsu_rsp_valid_i = 1'b1;
        bus.lsu_rsp_addr_i  = 5'd13;
        bus.lsu_rsp_data_i  = 32'hC0;
        tick();
        bus.lsu_rsp_valid_i = 1'b0;
        chk_wr("x0.push13", 1'b0, 5'd0, 32'd0);
        tick();
        chk_wr("x0.drained", 1'b1, 5'd13, 32'hC0);

        // Pop of r9 coinciding with a new load to r9 keeps it pending
        idle();
        bus.lsu_issue_i      = 1'b1;
        bus.lsu_issue_addr_i = 5'd9;
        bus.read_addr1_i     = 5'd9;
        tick();
        bus.lsu_issue_i = 1'b0;
        chk("sc.haz_set", 32'(bus.hazard_o), 32'd1);
        bus.lsu_rsp_valid_i = 1'b1;
        bus.lsu_rsp_addr_i  = 5'd9;
        bus.lsu_rsp_data_i  = 32'h99;
        tick();
        bus.lsu_rsp_valid_i = 1'b0;
        bus.lsu_issue_i     = 1'b1;
        chk("sc.haz_push", 32'(bus.hazard_o), 32'd1);
        tick();
        bus.lsu_issue_i = 1'b0;
        chk_wr("sc.wr", 1'b1, 5'd9, 32'h99);
        chk("sc.haz_keep", 32'(bus.hazard_o), 32'd1);
        chk("sc.fwd1", bus.read_data1_o, 32'h99);
        tick();
        chk("sc.haz_after", 32'(bus.hazard_o), 32'd1);

        // Fill the buffer and the scoreboard, then reset mid-cycle
        idle();
        bus.lsu_issue_i      = 1'b1;
        bus.lsu_issue_addr_i = 5'd14;
        bus.alu_wb_valid_i   = 1'b1;
        bus.alu_wb_addr_i    = 5'd3;
        bus.alu_wb_data_i    = 32'hD0;
        bus.lsu_rsp_valid_i  = 1'b1;
        bus.lsu_rsp_addr_i   = 5'd20;
        bus.lsu_rsp_data_i   = 32'hE0;
        tick();
        bus.lsu_issue_addr_i = 5'd15;
        bus.alu_wb_data_i    = 32'hD1;
        bus.lsu_rsp_addr_i   = 5'd21;
        bus.lsu_rsp_data_i   = 32'hE1;
        tick();
        idle();
        bus.read_addr1_i = 5'd14;
        bus.read_addr2_i = 5'd15;
        #1;
        chk("rs.ready_full", 32'(bus.lsu_rsp_ready_o), 32'd0);
        chk("rs.haz_pre", 32'(bus.hazard_o), 32'd1);
        chk_wr("rs.wr_pre", 1'b1, 5'd3, 32'hD1);
        #1;
        rst = 1'b1;
        #1;
        chk("rs.en",    32'(bus.write_en_o), 32'd0);
        chk("rs.addr",  32'(bus.write_addr_o), 32'd0);
        chk("rs.data",  bus.write_data_o, 32'd0);
        chk("rs.ready", 32'(bus.lsu_rsp_ready_o), 32'd1);
        chk("rs.haz",   32'(bus.hazard_o), 32'd0);
        chk("rs.nofwd", bus.read_data1_o, 32'h1111_1111);
        bus.read_addr1_i = 5'd9;
        #1;
        chk("rs.haz9", 32'(bus.hazard_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_wr("rs.post1", 1'b0, 5'd0, 32'd0);
        tick();
        chk_wr("rs.post2", 1'b0, 5'd0, 32'd0);
        chk("rs.ready_post", 32'(bus.lsu_rsp_ready_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
